// File: rtl/dram_rw_arbiter.sv
// Shared DRAM command port: round-robin r0 -> r1 -> w into a one-entry command register, with an
// in-order tag FIFO that steers read returns. Optional write-starvation priority: DRAM_ARB_WPRIO_EN.
module dram_rw_arbiter #(
   parameter int GBW          = 32,
   parameter int DBW          = 16,
   parameter int CSIZE        = 32,
   parameter int OUTSTD       = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,

   input  logic                   r0_rdy,
   output logic                   r0_ack,
   input  logic [GBW-1:0]         i_r0_addr,

   input  logic                   r1_rdy,
   output logic                   r1_ack,
   input  logic [GBW-1:0]         i_r1_addr,

   input  logic                   w_rdy,
   output logic                   w_ack,
   input  logic [GBW-1:0]         i_w_addr,
   input  logic [DBW*CSIZE-1:0]   i_w_data,
   input  logic [CSIZE-1:0]       i_w_mask,

   output logic                   cmd_rdy,
   input  logic                   cmd_ack,
   output logic                   o_cmd_we,
   output logic [GBW-1:0]         o_cmd_addr,
   output logic [DBW*CSIZE-1:0]   o_cmd_data,
   output logic [CSIZE-1:0]       o_cmd_mask,

   input  logic                   rd_rdy,
   output logic                   rd_ack,
   input  logic [DBW*CSIZE-1:0]   i_rd_data,

   output logic                   r0d_rdy,
   input  logic                   r0d_ack,
   output logic [DBW*CSIZE-1:0]   o_r0d_data,

   output logic                   r1d_rdy,
   input  logic                   r1d_ack,
   output logic [DBW*CSIZE-1:0]   o_r1d_data,

   output logic                   o_err
);

   localparam int LW = DBW * CSIZE;
   localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
   localparam int CW = $clog2(OUTSTD + 1);

   localparam logic [1:0] PORT_R0 = 2'd0;
   localparam logic [1:0] PORT_R1 = 2'd1;
   localparam logic [1:0] PORT_W  = 2'd2;

   if (OUTSTD < 2 || (OUTSTD & (OUTSTD - 1)) != 0 || STARVE_LIMIT < 1) begin : g_paramCheck
      $error("dram_rw_arbiter: OUTSTD must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   logic                r_cmdVld;
   logic                r_cmdWe;
   logic [GBW-1:0]      r_cmdAddr;
   logic [LW-1:0]       r_cmdData;
   logic [CSIZE-1:0]    r_cmdMask;
   logic [1:0]          r_last;

   logic [OUTSTD-1:0]   r_tags;
   logic [PW-1:0]       r_wrPtr;
   logic [PW-1:0]       r_rdPtr;
   logic [CW-1:0]       r_count;
   logic                r_err;

   logic                w_free;
   logic                w_rdOk;
   logic [2:0]          w_req;
   logic [2:0]          w_grant;
   logic                w_gntAny;
   logic [1:0]          w_gntPort;
   logic                w_wPrio;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_headTag;

   // The stage can take a new command when it is empty or its current one leaves this cycle.
   assign w_free   = ~r_cmdVld | cmd_ack;
   assign w_rdOk   = (r_count < CW'(OUTSTD));
   assign w_req    = {w_rdy, r1_rdy & w_rdOk, r0_rdy & w_rdOk};

   always_comb begin
      w_grant = 3'b000;
      if (w_free && !i_rst) begin
         if (w_wPrio && w_req[2]) begin
            w_grant = 3'b100;
         end else begin
            case (r_last)
               PORT_R0: w_grant = w_req[1] ? 3'b010 : w_req[2] ? 3'b100 : w_req[0] ? 3'b001 : 3'b000;
               PORT_R1: w_grant = w_req[2] ? 3'b100 : w_req[0] ? 3'b001 : w_req[1] ? 3'b010 : 3'b000;
               default: w_grant = w_req[0] ? 3'b001 : w_req[1] ? 3'b010 : w_req[2] ? 3'b100 : 3'b000;
            endcase
         end
      end
   end

   assign w_gntAny  = |w_grant;
   assign w_gntPort = w_grant[2] ? PORT_W : (w_grant[1] ? PORT_R1 : PORT_R0);

   assign r0_ack = w_grant[0];
   assign r1_ack = w_grant[1];
   assign w_ack  = w_grant[2];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cmdVld  <= 1'b0;
         r_cmdWe   <= 1'b0;
         r_cmdAddr <= '0;
         r_cmdData <= '0;
         r_cmdMask <= '0;
         r_last    <= PORT_W;
      end else if (w_gntAny) begin
         r_cmdVld <= 1'b1;
         r_last   <= w_gntPort;
         if (w_grant[2]) begin
            r_cmdWe   <= 1'b1;
            r_cmdAddr <= i_w_addr;
            r_cmdData <= i_w_data;
            r_cmdMask <= i_w_mask;
         end else begin
            r_cmdWe   <= 1'b0;
            r_cmdAddr <= w_grant[1] ? i_r1_addr : i_r0_addr;
            r_cmdData <= '0;
            r_cmdMask <= '0;
         end
      end else if (cmd_ack) begin
         r_cmdVld <= 1'b0;
      end
   end

   assign cmd_rdy    = r_cmdVld;
   assign o_cmd_we   = r_cmdWe;
   assign o_cmd_addr = r_cmdAddr;
   assign o_cmd_data = r_cmdData;
   assign o_cmd_mask = r_cmdMask;

   // Read returns arrive in issue order, so the FIFO head names the owner of the current line.
   assign w_empty    = (r_count == '0);
   assign w_headTag  = r_tags[r_rdPtr];
   assign r0d_rdy    = rd_rdy & ~w_empty & ~w_headTag;
   assign r1d_rdy    = rd_rdy & ~w_empty &  w_headTag;
   assign o_r0d_data = i_rd_data;
   assign o_r1d_data = i_rd_data;
   assign rd_ack     = ~w_empty & (w_headTag ? r1d_ack : r0d_ack);

   assign w_push = w_grant[0] | w_grant[1];
   assign w_pop  = rd_rdy & rd_ack;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tags  <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tags[r_wrPtr] <= w_grant[1];
            r_wrPtr         <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (rd_rdy && w_empty) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;

`ifdef DRAM_ARB_WPRIO_EN
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   logic [SCW-1:0] r_starveCnt;

   // Counts cycles a write has been left waiting; once saturated it overrides round-robin.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_ack) begin
         r_starveCnt <= '0;
      end else if (w_rdy && (r_starveCnt != SCW'(STARVE_LIMIT))) begin
         r_starveCnt <= r_starveCnt + SCW'(1);
      end
   end

   assign w_wPrio = (r_starveCnt == SCW'(STARVE_LIMIT));
`else
   assign w_wPrio = 1'b0;
`endif

endmodule

// File: tb/tb_dram_rw_arbiter.sv
// Bench for dram_rw_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference model of the arbitration, command stage and read-return routing.
module tb_dram_rw_arbiter;

   localparam int GBW          = 32;
   localparam int DBW          = 16;
   localparam int CSIZE        = 32;
   localparam int OUTSTD       = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int LW           = DBW * CSIZE;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             r0_rdy, r0_ack;
   logic [GBW-1:0]   i_r0_addr;
   logic             r1_rdy, r1_ack;
   logic [GBW-1:0]   i_r1_addr;
   logic             w_rdy, w_ack;
   logic [GBW-1:0]   i_w_addr;
   logic [LW-1:0]    i_w_data;
   logic [CSIZE-1:0] i_w_mask;
   logic             cmd_rdy, cmd_ack, o_cmd_we;
   logic [GBW-1:0]   o_cmd_addr;
   logic [LW-1:0]    o_cmd_data;
   logic [CSIZE-1:0] o_cmd_mask;
   logic             rd_rdy, rd_ack;
   logic [LW-1:0]    i_rd_data;
   logic             r0d_rdy, r0d_ack;
   logic [LW-1:0]    o_r0d_data;
   logic             r1d_rdy, r1d_ack;
   logic [LW-1:0]    o_r1d_data;
   logic             o_err;

   dram_rw_arbiter #(
      .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .OUTSTD(OUTSTD), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .r0_rdy(r0_rdy), .r0_ack(r0_ack), .i_r0_addr(i_r0_addr),
      .r1_rdy(r1_rdy), .r1_ack(r1_ack), .i_r1_addr(i_r1_addr),
      .w_rdy(w_rdy), .w_ack(w_ack), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_w_mask(i_w_mask),
      .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack), .o_cmd_we(o_cmd_we), .o_cmd_addr(o_cmd_addr),
      .o_cmd_data(o_cmd_data), .o_cmd_mask(o_cmd_mask),
      .rd_rdy(rd_rdy), .rd_ack(rd_ack), .i_rd_data(i_rd_data),
      .r0d_rdy(r0d_rdy), .r0d_ack(r0d_ack), .o_r0d_data(o_r0d_data),
      .r1d_rdy(r1d_rdy), .r1d_ack(r1d_ack), .o_r1d_data(o_r1d_data),
      .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   // Reference model state: last winner as 0/1/2, in-flight read owners as a queue.
   logic             mVld, mWe, mErr;
   logic [GBW-1:0]   mAddr;
   logic [LW-1:0]    mData;
   logic [CSIZE-1:0] mMask;
   int               mLast;
   int               mTags[$];
   int               mStarve;

   int               lastGrant;
   bit               lastPop;
   logic [2:0]       obsAcks;
   logic [1:0]       obsRoute;
   logic             obsRdAck, obsErr, obsCmdRdy, obsWe;
   logic [GBW-1:0]   obsAddr;
   logic [CSIZE-1:0] obsMask;
   logic [2:0]       expOne;

   int nChecks = 0;
   int nErrors = 0;

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      nChecks++;
      assert (obs === expv) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [LW-1:0] randLine();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int modelGrant();
      bit req[3];
      int p;
      if (i_rst) return -1;
      if (mVld && !cmd_ack) return -1;
      req[0] = r0_rdy && (mTags.size() < OUTSTD);
      req[1] = r1_rdy && (mTags.size() < OUTSTD);
      req[2] = w_rdy;
`ifdef DRAM_ARB_WPRIO_EN
      if (w_rdy && mStarve == STARVE_LIMIT) return 2;
`endif
      for (int k = 1; k <= 3; k++) begin
         p = (mLast + k) % 3;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   // One clock cycle: inputs already driven, sample mid-cycle, compare, advance the model.
   task automatic applyStimulus();
      int g, head;
      bit empty, pop;
      logic expR0d, expR1d, expRdAck;
      #3;
      g        = modelGrant();
      empty    = (mTags.size() == 0);
      head     = empty ? 0 : mTags[0];
      expR0d   = rd_rdy && !empty && head == 0;
      expR1d   = rd_rdy && !empty && head == 1;
      expRdAck = !empty && (head == 1 ? r1d_ack : r0d_ack);
      obsAcks   = {w_ack, r1_ack, r0_ack};
      obsRoute  = {r1d_rdy, r0d_rdy};
      obsRdAck  = rd_ack;
      obsErr    = o_err;
      obsCmdRdy = cmd_rdy;
      obsWe     = o_cmd_we;
      obsAddr   = o_cmd_addr;
      obsMask   = o_cmd_mask;
      if (!i_rst) begin
         checkOutput("r0_ack", 512'(r0_ack), 512'(g == 0));
         checkOutput("r1_ack", 512'(r1_ack), 512'(g == 1));
         checkOutput("w_ack", 512'(w_ack), 512'(g == 2));
         checkOutput("cmd_rdy", 512'(cmd_rdy), 512'(mVld));
         checkOutput("cmd_we", 512'(o_cmd_we), 512'(mWe));
         checkOutput("cmd_addr", 512'(o_cmd_addr), 512'(mAddr));
         checkOutput("cmd_data", o_cmd_data, mData);
         checkOutput("cmd_mask", 512'(o_cmd_mask), 512'(mMask));
         checkOutput("r0d_rdy", 512'(r0d_rdy), 512'(expR0d));
         checkOutput("r1d_rdy", 512'(r1d_rdy), 512'(expR1d));
         checkOutput("rd_ack", 512'(rd_ack), 512'(expRdAck));
         checkOutput("o_err", 512'(o_err), 512'(mErr));
         if (expR0d) checkOutput("r0d_data", o_r0d_data, i_rd_data);
         if (expR1d) checkOutput("r1d_data", o_r1d_data, i_rd_data);
      end
      pop = rd_rdy && expRdAck;
      if (i_rst) begin
         mVld = 0; mWe = 0; mAddr = '0; mData = '0; mMask = '0;
         mLast = 2; mTags.delete(); mErr = 0; mStarve = 0; pop = 0;
      end else begin
         if (rd_rdy && empty) mErr = 1;
         if (pop) void'(mTags.pop_front());
         if (g == 2) mStarve = 0;
         else if (w_rdy && mStarve < STARVE_LIMIT) mStarve++;
         if (g >= 0) begin
            mLast = g;
            mVld  = 1;
            if (g == 2) begin
               mWe = 1; mAddr = i_w_addr; mData = i_w_data; mMask = i_w_mask;
            end else begin
               mWe = 0; mAddr = (g == 1) ? i_r1_addr : i_r0_addr; mData = '0; mMask = '0;
               mTags.push_back(g);
            end
         end else if (cmd_ack) begin
            mVld = 0;
         end
      end
      lastGrant = g;
      lastPop   = pop;
      @(posedge i_clk);
      #1;
   endtask

   task automatic resetDut();
      i_rst = 1; r0_rdy = 0; r1_rdy = 0; w_rdy = 0; rd_rdy = 0;
      cmd_ack = 0; r0d_ack = 0; r1d_ack = 0;
      applyStimulus();
      applyStimulus();
      i_rst = 0;
      applyStimulus();
      checkOutput("rst_cmd_rdy", 512'(obsCmdRdy), 512'(0));
      checkOutput("rst_cmd_addr", 512'(obsAddr), 512'(0));
      checkOutput("rst_err", 512'(obsErr), 512'(0));
   endtask

   // Requesters refresh payload only after being acknowledged; read data holds until popped.
   task automatic randomTraffic(input int cycles, input bit allReq, input bit toggleAck);
      for (int c = 0; c < cycles; c++) begin
         if (!r0_rdy && (allReq || $urandom_range(0, 2) == 0)) begin r0_rdy = 1; i_r0_addr = $urandom; end
         if (!r1_rdy && (allReq || $urandom_range(0, 2) == 0)) begin r1_rdy = 1; i_r1_addr = $urandom; end
         if (!w_rdy && (allReq || $urandom_range(0, 2) == 0)) begin
            w_rdy = 1; i_w_addr = $urandom; i_w_data = randLine(); i_w_mask = $urandom;
         end
         cmd_ack = toggleAck ? ((c % 2) == 0) : ($urandom_range(0, 3) != 0);
         if (!rd_rdy && mTags.size() > 0 && $urandom_range(0, 1) == 1) begin
            rd_rdy = 1; i_rd_data = randLine();
         end
         r0d_ack = toggleAck ? 1'b1 : ($urandom_range(0, 3) != 0);
         r1d_ack = toggleAck ? 1'b1 : ($urandom_range(0, 3) != 0);
         applyStimulus();
         if (lastGrant == 0) r0_rdy = 0;
         if (lastGrant == 1) r1_rdy = 0;
         if (lastGrant == 2) w_rdy = 0;
         if (lastPop) rd_rdy = 0;
      end
   endtask

   initial begin
      i_rst = 1; r0_rdy = 0; r1_rdy = 0; w_rdy = 0; rd_rdy = 0;
      cmd_ack = 0; r0d_ack = 0; r1d_ack = 0;
      i_r0_addr = '0; i_r1_addr = '0; i_w_addr = '0; i_w_data = '0; i_w_mask = '0; i_rd_data = '0;
      @(posedge i_clk);
      #1;

      // All three requesting with the command port always accepting.
      resetDut();
      r0_rdy = 1; r1_rdy = 1; w_rdy = 1; cmd_ack = 1;
      i_r0_addr = 32'h1000; i_r1_addr = 32'h2000; i_w_addr = 32'h3000;
      i_w_data = randLine(); i_w_mask = 32'h0000FFFF;
      for (int c = 0; c < 6; c++) begin
         applyStimulus();
         expOne = 3'b001 << (c % 3);
         checkOutput("rr_order", 512'(obsAcks), 512'(expOne));
         if (c > 0) checkOutput("rr_we", 512'(obsWe), 512'((c - 1) % 3 == 2));
         i_r0_addr = i_r0_addr + 32'h4; i_r1_addr = i_r1_addr + 32'h4; i_w_addr = i_w_addr + 32'h4;
      end
      r0_rdy = 0; r1_rdy = 0; w_rdy = 0;
      applyStimulus();
      checkOutput("rr_we_last", 512'(obsWe), 512'(1));

      // Tag FIFO fills at OUTSTD reads; a pop in the full cycle does not free a slot until next cycle.
      resetDut();
      r0_rdy = 1; cmd_ack = 1; i_r0_addr = 32'h500;
      for (int c = 0; c < 7; c++) begin
         applyStimulus();
         checkOutput("full_ack", 512'(obsAcks[0]), 512'(c < 4));
         if (lastGrant == 0) i_r0_addr = i_r0_addr + 32'h40;
      end
      rd_rdy = 1; r0d_ack = 1; i_rd_data = randLine();
      applyStimulus();
      checkOutput("full_pop_ack", 512'(obsAcks[0]), 512'(0));
      checkOutput("full_pop_rdack", 512'(obsRdAck), 512'(1));
      rd_rdy = 0;
      applyStimulus();
      checkOutput("full_regrant", 512'(obsAcks[0]), 512'(1));
      r0_rdy = 0;
      applyStimulus();

      // Returns routed by issue order r1, r0, r1; FIFO then empty so a further line is an error.
      resetDut();
      cmd_ack = 1;
      r1_rdy = 1; i_r1_addr = 32'h100; applyStimulus(); r1_rdy = 0;
      r0_rdy = 1; i_r0_addr = 32'h200; applyStimulus(); r0_rdy = 0;
      checkOutput("route_addr0", 512'(obsAddr), 512'(32'h100));
      r1_rdy = 1; i_r1_addr = 32'h300; applyStimulus(); r1_rdy = 0;
      checkOutput("route_addr1", 512'(obsAddr), 512'(32'h200));
      applyStimulus();
      checkOutput("route_addr2", 512'(obsAddr), 512'(32'h300));
      rd_rdy = 1; r0d_ack = 1; r1d_ack = 1;
      for (int c = 0; c < 3; c++) begin
         i_rd_data = randLine();
         applyStimulus();
         checkOutput("route_dest", 512'(obsRoute), 512'((c == 1) ? 2'b01 : 2'b10));
      end
      applyStimulus();
      checkOutput("empty_route", 512'(obsRoute), 512'(0));
      checkOutput("empty_rdack", 512'(obsRdAck), 512'(0));
      rd_rdy = 0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus();
         checkOutput("err_sticky", 512'(obsErr), 512'(1));
      end

      // Line returned right after reset with nothing issued.
      resetDut();
      rd_rdy = 1; i_rd_data = randLine(); r0d_ack = 1; r1d_ack = 1;
      applyStimulus();
      checkOutput("err_rdack", 512'(obsRdAck), 512'(0));
      checkOutput("err_route", 512'(obsRoute), 512'(0));
      rd_rdy = 0;
      applyStimulus();
      checkOutput("err_set", 512'(obsErr), 512'(1));

      // Command stalled by the DRAM: payload holds and no new grants are made.
      resetDut();
      w_rdy = 1; i_w_addr = 32'h40; i_w_mask = 32'hFFFF0000; i_w_data = randLine(); cmd_ack = 0;
      applyStimulus();
      checkOutput("stall_grant", 512'(obsAcks), 512'(3'b100));
      r0_rdy = 1; i_r0_addr = 32'h80;
      for (int c = 0; c < 5; c++) begin
         applyStimulus();
         checkOutput("stall_rdy", 512'(obsCmdRdy), 512'(1));
         checkOutput("stall_addr", 512'(obsAddr), 512'(32'h40));
         checkOutput("stall_mask", 512'(obsMask), 512'(32'hFFFF0000));
         checkOutput("stall_noack", 512'(obsAcks), 512'(0));
      end
      cmd_ack = 1;
      applyStimulus();
      checkOutput("stall_release", 512'(obsAcks), 512'(3'b001));
      r0_rdy = 0; w_rdy = 0;
      applyStimulus();

      // Saturated read traffic with a half-rate command port, then free-running random traffic.
      resetDut();
      randomTraffic(60, 1'b1, 1'b1);
      r0_rdy = 0; r1_rdy = 0; w_rdy = 0; rd_rdy = 0;
      resetDut();
      randomTraffic(500, 1'b0, 1'b0);
      resetDut();
      randomTraffic(500, 1'b0, 1'b0);
      r0_rdy = 0; r1_rdy = 0; w_rdy = 0; rd_rdy = 0;
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
